multi_source_sequencer: RTL

Per-frame sequencer that merges NUM_SRC vertex-stream generators into the single vertex/color/new_triangle stream consumed by the 3D projector. It activates each enabled source in ascending index order, forwards that source's stream, and bounds each source with a watchdog. After the last source it flushes the projector, then raises a level done back to the frame controller. It generalises the fixed obstacle-then-sprite ordering to N sources, with enable masking, timeouts and per-frame triangle counting.

---
 rtl/multi_source_pkg.sv | 49 ++++
 rtl/source_watchdog.sv | 35 +++
 rtl/multi_source_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/multi_source_pkg.sv
// Shared types and helpers for the multi-source vertex sequencer.
// Source selection walks a fixed 8-bit mask so one helper serves any NUM_SRC up to 8.
package multi_source_pkg;

    localparam int VERTEX_W_DEF = 48;
    localparam int COLOR_W_DEF  = 16;
    localparam int MAX_SRC      = 8;
    localparam int IDX_W        = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_GUARD,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } src_sel_t;

    // Lowest set bit strictly above cur.
    function automatic src_sel_t next_src(input logic [MAX_SRC-1:0] mask,
                                          input logic [IDX_W-1:0]   cur);
        src_sel_t sel;
        sel = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                sel.valid = 1'b1;
                sel.idx   = IDX_W'(i);
            end
        end
        return sel;
    endfunction

    function automatic src_sel_t first_src(input logic [MAX_SRC-1:0] mask);
        src_sel_t sel;
        if (mask[0]) begin
            sel.valid = 1'b1;
            sel.idx   = '0;
        end else begin
            sel = next_src(mask, '0);
        end
        return sel;
    endfunction

endpackage

// File: rtl/source_watchdog.sv
// Cycle counter with synchronous clear/enable and a terminal-count flag,
// used to bound how long a single source may hold the output stream.
module source_watchdog #(
    parameter int TERMINAL = 4095,
    parameter int CNT_W    = (TERMINAL < 1) ? 1 : $clog2(TERMINAL + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == CNT_W'(TERMINAL));

endmodule

// File: rtl/multi_source_sequencer.sv
// Merges NUM_SRC vertex generators into one projector stream, servicing enabled
// sources in ascending order with a per-source watchdog, then flushing the projector.
module multi_source_sequencer
    import multi_source_pkg::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int VERTEX_W       = VERTEX_W_DEF,
    parameter int COLOR_W        = COLOR_W_DEF,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_req,
    input  logic [NUM_SRC-1:0]          src_enable,
    output logic [NUM_SRC-1:0]          src_activate,
    input  logic [NUM_SRC-1:0]          src_active,
    input  logic [NUM_SRC*VERTEX_W-1:0] src_vertex,
    input  logic [NUM_SRC*COLOR_W-1:0]  src_color,
    input  logic [NUM_SRC-1:0]          src_new_triangle,
    output logic [VERTEX_W-1:0]         vertex,
    output logic [COLOR_W-1:0]          color,
    output logic                        new_triangle,
    output logic                        flush,
    input  logic                        proj_done,
    output logic                        done_out,
    output logic                        timeout_err,
    output logic [NUM_SRC-1:0]          timed_out_mask,
    output logic [15:0]                 tri_count
);

    seq_state_e           state_q, state_d;
    logic [NUM_SRC-1:0]   en_q, en_d;
    logic [NUM_SRC-1:0]   tmask_q, tmask_d;
    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [VERTEX_W-1:0]  vertex_q, vertex_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic                 ntri_q, ntri_d;
    logic                 err_q, err_d;
    logic [15:0]          tri_count_q, tri_count_d;

    logic                 wd_clr, wd_en, wd_tc;
    src_sel_t             first_sel, next_sel;
    logic [VERTEX_W-1:0]  sel_vertex;
    logic [COLOR_W-1:0]   sel_color;
    logic                 sel_ntri, sel_active;
    logic [NUM_SRC-1:0]   cur_onehot;

    source_watchdog #(
        .TERMINAL(TIMEOUT_CYCLES - 1)
    ) u_watchdog (
        .clk(clk),
        .rst(rst),
        .clr(wd_clr),
        .en (wd_en),
        .tc (wd_tc)
    );

    assign first_sel = first_src(MAX_SRC'(src_enable));
    assign next_sel  = next_src(MAX_SRC'(en_q), cur_q);

    always_comb begin
        sel_vertex = '0;
        sel_color  = '0;
        sel_ntri   = 1'b0;
        sel_active = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_q == IDX_W'(i)) begin
                sel_vertex    = src_vertex[i*VERTEX_W +: VERTEX_W];
                sel_color     = src_color[i*COLOR_W +: COLOR_W];
                sel_ntri      = src_new_triangle[i];
                sel_active    = src_active[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        cur_d       = cur_q;
        vertex_d    = vertex_q;
        color_d     = color_q;
        ntri_d      = 1'b0;
        tri_count_d = tri_count_q;
        err_d       = err_q;
        tmask_d     = tmask_q;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_req) begin
                    en_d        = src_enable;
                    tri_count_d = '0;
                    err_d       = 1'b0;
                    tmask_d     = '0;
                    if (first_sel.valid) begin
                        cur_d   = first_sel.idx;
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_LAUNCH: begin
                wd_clr  = 1'b1;
                state_d = ST_GUARD;
            end
            ST_GUARD: state_d = ST_RUN;
            ST_RUN: begin
                vertex_d = sel_vertex;
                color_d  = sel_color;
                ntri_d   = sel_ntri;
                wd_en    = 1'b1;
                if (sel_ntri && (tri_count_q != 16'hFFFF)) begin
                    tri_count_d = tri_count_q + 16'd1;
                end
                // An active drop on the terminal cycle is a clean finish, not a timeout.
                if (!sel_active || wd_tc) begin
                    if (sel_active) begin
                        err_d   = 1'b1;
                        tmask_d = tmask_q | cur_onehot;
                    end
                    if (next_sel.valid) begin
                        cur_d   = next_sel.idx;
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (proj_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!frame_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            en_q        <= '0;
            cur_q       <= '0;
            vertex_q    <= '0;
            color_q     <= '0;
            ntri_q      <= 1'b0;
            tri_count_q <= '0;
            err_q       <= 1'b0;
            tmask_q     <= '0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            cur_q       <= cur_d;
            vertex_q    <= vertex_d;
            color_q     <= color_d;
            ntri_q      <= ntri_d;
            tri_count_q <= tri_count_d;
            err_q       <= err_d;
            tmask_q     <= tmask_d;
        end
    end

    assign src_activate   = (state_q == ST_LAUNCH) ? cur_onehot : '0;
    assign flush          = (state_q == ST_FLUSH);
    assign done_out       = (state_q == ST_DONE);
    assign vertex         = vertex_q;
    assign color          = color_q;
    assign new_triangle   = ntri_q;
    assign tri_count      = tri_count_q;
    assign timeout_err    = err_q;
    assign timed_out_mask = tmask_q;

endmodule
